seg7_scan_ctrl: RTL and testbench

//  Time-multiplexed scan controller for an N-digit common-segment 7-segment display.

---
 rtl/seg7_scan_ctrl.sv | 170 +++++++++++++++++
 tb/tb_seg7_scan_ctrl.sv | 293 +++++++++++++++++++++++++++++
 2 files changed

// File: rtl/seg7_scan_ctrl.sv
// Time-multiplexed scan controller for an N-digit common-segment 7-segment display.
// Per-digit code/blank store, PWM slot brightness and frame-boundary write commit.
module seg7_scan_ctrl #(
    parameter int NUM_DIGITS = 4,
    parameter int SCAN_DIV   = 1000,
    parameter int IDX_W      = $clog2(NUM_DIGITS)
) (
    input  logic                  clk,
    input  logic                  rst_n,
    input  logic                  enable,
    input  logic [2:0]            brightness,
    input  logic                  wr_valid,
    output logic                  wr_ready,
    input  logic [IDX_W-1:0]      wr_digit,
    input  logic [3:0]            wr_data,
    input  logic                  wr_blank,
    output logic [3:0]            digit_code,
    output logic [NUM_DIGITS-1:0] digit_sel,
    output logic                  seg_en,
    output logic                  frame_done
);

    localparam int CNT_W = $clog2(SCAN_DIV);
    localparam int STEP  = SCAN_DIV / 8;
    // Store is padded to a power of two so any idx value selects a defined entry.
    localparam int DEPTH = 1 << IDX_W;

    localparam logic [1:0] ST_IDLE = 2'd0;
    localparam logic [1:0] ST_ON   = 2'd1;
    localparam logic [1:0] ST_OFF  = 2'd2;

    logic [1:0]       state_reg, state_next;
    logic [IDX_W-1:0] idx_reg, idx_next;
    logic [CNT_W-1:0] cnt_reg, cnt_next;
    logic [2:0]       br_reg, br_next;

    logic             pending_reg;
    logic [IDX_W-1:0] sh_digit_reg;
    logic [3:0]       sh_data_reg;
    logic             sh_blank_reg;

    logic [3:0]       value_reg [DEPTH];
    logic             blank_reg [DEPTH];
    logic [DEPTH-1:0] store_we;

    logic             slot_end;
    logic             last_digit;
    logic [CNT_W-1:0] on_last;
    logic             accept;
    logic             commit;
    logic [3:0]       cur_code;
    logic             cur_blank;

    assign slot_end   = (cnt_reg == CNT_W'(SCAN_DIV - 1));
    assign last_digit = (idx_reg == IDX_W'(NUM_DIGITS - 1));
    assign on_last    = CNT_W'((int'(br_reg) + 1) * STEP - 1);

    always_comb begin
        state_next = state_reg;
        idx_next   = idx_reg;
        cnt_next   = cnt_reg;
        br_next    = br_reg;
        if (!enable) begin
            state_next = ST_IDLE;
            idx_next   = '0;
            cnt_next   = '0;
        end else begin
            case (state_reg)
                ST_IDLE: begin
                    state_next = ST_ON;
                    idx_next   = '0;
                    cnt_next   = '0;
                    br_next    = brightness;
                end
                ST_ON, ST_OFF: begin
                    if (slot_end) begin
                        state_next = ST_ON;
                        cnt_next   = '0;
                        idx_next   = last_digit ? '0 : idx_reg + 1'b1;
                        br_next    = brightness;
                    end else begin
                        cnt_next = cnt_reg + 1'b1;
                        // Full brightness never enters OFF within a slot.
                        if (state_reg == ST_ON && cnt_reg == on_last && br_reg != 3'd7) begin
                            state_next = ST_OFF;
                        end
                    end
                end
                default: begin
                    state_next = ST_IDLE;
                    idx_next   = '0;
                    cnt_next   = '0;
                end
            endcase
        end
    end

    always_ff @(posedge clk) begin
        if (!rst_n) begin
            state_reg <= ST_IDLE;
            idx_reg   <= '0;
            cnt_reg   <= '0;
            br_reg    <= '0;
        end else begin
            state_reg <= state_next;
            idx_reg   <= idx_next;
            cnt_reg   <= cnt_next;
            br_reg    <= br_next;
        end
    end

    assign frame_done = (state_reg != ST_IDLE) && slot_end && last_digit;
    assign wr_ready   = !pending_reg;
    assign accept     = wr_valid && !pending_reg;
    // While scanning, updates land only on a frame boundary so a frame never tears.
    assign commit     = pending_reg && (!enable || frame_done);

    always_ff @(posedge clk) begin
        if (!rst_n) begin
            pending_reg  <= 1'b0;
            sh_digit_reg <= '0;
            sh_data_reg  <= '0;
            sh_blank_reg <= 1'b0;
        end else if (accept) begin
            pending_reg  <= 1'b1;
            sh_digit_reg <= wr_digit;
            sh_data_reg  <= wr_data;
            sh_blank_reg <= wr_blank;
        end else if (commit) begin
            pending_reg  <= 1'b0;
        end
    end

    // Entries at or beyond NUM_DIGITS never get a write enable: such writes are dropped.
    generate
        for (genvar gi = 0; gi < DEPTH; gi++) begin : g_store_we
            localparam bit IN_RANGE = (gi < NUM_DIGITS);
            assign store_we[gi] = IN_RANGE && commit && (sh_digit_reg == IDX_W'(gi));
        end
    endgenerate

    always_ff @(posedge clk) begin
        if (!rst_n) begin
            for (int i = 0; i < DEPTH; i++) begin
                value_reg[i] <= 4'd0;
                blank_reg[i] <= 1'b1;
            end
        end else begin
            for (int i = 0; i < DEPTH; i++) begin
                if (store_we[i]) begin
                    value_reg[i] <= sh_data_reg;
                    blank_reg[i] <= sh_blank_reg;
                end
            end
        end
    end

    assign cur_code  = value_reg[idx_reg];
    assign cur_blank = blank_reg[idx_reg];

    assign digit_code = (state_reg != ST_IDLE) ? cur_code : 4'd0;
    assign seg_en     = (state_reg == ST_ON) && !cur_blank;

    generate
        for (genvar gi = 0; gi < NUM_DIGITS; gi++) begin : g_digit_sel
            assign digit_sel[gi] = (state_reg == ST_ON) && (idx_reg == IDX_W'(gi));
        end
    endgenerate

endmodule

// File: tb/tb_seg7_scan_ctrl.sv
// Directed bench for seg7_scan_ctrl: a 4-digit instance and a 3-digit instance,
// both with SCAN_DIV = 16, checked against hand-computed scan timing.
module tb_seg7_scan_ctrl;

    logic clk   = 1'b0;
    logic rst_n = 1'b0;
    always #5 clk = ~clk;

    logic       enable     = 1'b0;
    logic [2:0] brightness = 3'd7;
    logic       wr_valid   = 1'b0;
    logic [1:0] wr_digit   = 2'd0;
    logic [3:0] wr_data    = 4'd0;
    logic       wr_blank   = 1'b1;
    logic       wr_ready;
    logic [3:0] digit_code;
    logic [3:0] digit_sel;
    logic       seg_en;
    logic       frame_done;

    logic       enable3     = 1'b0;
    logic [2:0] brightness3 = 3'd7;
    logic       wr_valid3   = 1'b0;
    logic [1:0] wr_digit3   = 2'd0;
    logic [3:0] wr_data3    = 4'd0;
    logic       wr_blank3   = 1'b1;
    logic       wr_ready3;
    logic [3:0] digit_code3;
    logic [2:0] digit_sel3;
    logic       seg_en3;
    logic       frame_done3;

    int n_checks = 0;
    int n_fail   = 0;
    int k        = 0;

    seg7_scan_ctrl #(.NUM_DIGITS(4), .SCAN_DIV(16)) dut (
        .clk(clk), .rst_n(rst_n), .enable(enable), .brightness(brightness),
        .wr_valid(wr_valid), .wr_ready(wr_ready), .wr_digit(wr_digit),
        .wr_data(wr_data), .wr_blank(wr_blank), .digit_code(digit_code),
        .digit_sel(digit_sel), .seg_en(seg_en), .frame_done(frame_done)
    );

    seg7_scan_ctrl #(.NUM_DIGITS(3), .SCAN_DIV(16)) dut3 (
        .clk(clk), .rst_n(rst_n), .enable(enable3), .brightness(brightness3),
        .wr_valid(wr_valid3), .wr_ready(wr_ready3), .wr_digit(wr_digit3),
        .wr_data(wr_data3), .wr_blank(wr_blank3), .digit_code(digit_code3),
        .digit_sel(digit_sel3), .seg_en(seg_en3), .frame_done(frame_done3)
    );

    task automatic tick();
        @(posedge clk);
        #1;
        k++;
    endtask

    task automatic run_to(input int target);
        while (k < target) tick();
    endtask

    task automatic apply_reset();
        rst_n = 1'b0; enable = 1'b0; enable3 = 1'b0;
        wr_valid = 1'b0; wr_valid3 = 1'b0;
        brightness = 3'd7; brightness3 = 3'd7;
        tick(); tick();
        rst_n = 1'b1;
    endtask

    // Enable is raised between edges; the next edge enters ON at digit 0, cnt 0 (k = 0).
    task automatic start_scan();
        enable = 1'b1;
        k = -1;
        tick();
    endtask

    task automatic test_reset();
        apply_reset();
        start_scan();
        run_to(18);
        wr_valid = 1'b1; wr_digit = 2'd1; wr_data = 4'hC; wr_blank = 1'b0;
        tick();
        wr_valid = 1'b0;
        rst_n = 1'b0; enable = 1'b1; enable3 = 1'b1;
        tick(); tick();
        n_checks++; if (digit_sel !== 4'b0000) begin n_fail++; $display("FAIL reset_digit_sel: got %b expected 0000", digit_sel); end
        n_checks++; if (seg_en !== 1'b0) begin n_fail++; $display("FAIL reset_seg_en: got %b expected 0", seg_en); end
        n_checks++; if (digit_code !== 4'h0) begin n_fail++; $display("FAIL reset_digit_code: got %h expected 0", digit_code); end
        n_checks++; if (frame_done !== 1'b0) begin n_fail++; $display("FAIL reset_frame_done: got %b expected 0", frame_done); end
        n_checks++; if (wr_ready !== 1'b1) begin n_fail++; $display("FAIL reset_wr_ready: got %b expected 1", wr_ready); end
        n_checks++; if (wr_ready3 !== 1'b1) begin n_fail++; $display("FAIL reset_wr_ready3: got %b expected 1", wr_ready3); end
        n_checks++; if (digit_sel3 !== 3'b000) begin n_fail++; $display("FAIL reset_digit_sel3: got %b expected 000", digit_sel3); end
        rst_n = 1'b1; enable3 = 1'b0;
        // The dropped write must not reappear: digit 1 stays blank, code 0.
        start_scan();
        run_to(16);
        n_checks++; if (digit_code !== 4'h0) begin n_fail++; $display("FAIL reset_dropped_code: got %h expected 0", digit_code); end
        n_checks++; if (seg_en !== 1'b0) begin n_fail++; $display("FAIL reset_dropped_seg_en: got %b expected 0", seg_en); end
    endtask

    task automatic test_scan();
        logic [3:0] exp_sel;
        logic       exp_fd;
        apply_reset();
        brightness = 3'd7;
        start_scan();
        for (int i = 0; i < 128; i++) begin
            exp_sel = 4'b0001 << ((i / 16) % 4);
            exp_fd  = ((i % 64) == 63);
            n_checks++; if (digit_sel !== exp_sel) begin n_fail++; $display("FAIL scan_digit_sel k=%0d: got %b expected %b", k, digit_sel, exp_sel); end
            n_checks++; if (seg_en !== 1'b0) begin n_fail++; $display("FAIL scan_seg_en k=%0d: got %b expected 0", k, seg_en); end
            n_checks++; if (frame_done !== exp_fd) begin n_fail++; $display("FAIL scan_frame_done k=%0d: got %b expected %b", k, frame_done, exp_fd); end
            tick();
        end
    endtask

    task automatic test_write();
        apply_reset();
        brightness = 3'd7;
        start_scan();
        run_to(20);
        n_checks++; if (wr_ready !== 1'b1) begin n_fail++; $display("FAIL write_ready_idle: got %b expected 1", wr_ready); end
        wr_valid = 1'b1; wr_digit = 2'd2; wr_data = 4'h5; wr_blank = 1'b0;
        $display("write digit=2 data=5 blank=0 offered at k=%0d", k);
        tick();
        wr_valid = 1'b0;
        while (k < 64) begin
            n_checks++; if (wr_ready !== 1'b0) begin n_fail++; $display("FAIL write_ready_pending k=%0d: got %b expected 0", k, wr_ready); end
            if (k == 40) begin
                n_checks++; if (digit_code !== 4'h0) begin n_fail++; $display("FAIL write_early_code: got %h expected 0", digit_code); end
                n_checks++; if (seg_en !== 1'b0) begin n_fail++; $display("FAIL write_early_seg_en: got %b expected 0", seg_en); end
            end
            tick();
        end
        n_checks++; if (wr_ready !== 1'b1) begin n_fail++; $display("FAIL write_ready_after_commit: got %b expected 1", wr_ready); end
        run_to(80);
        n_checks++; if (digit_code !== 4'h0) begin n_fail++; $display("FAIL write_other_digit_code: got %h expected 0", digit_code); end
        n_checks++; if (seg_en !== 1'b0) begin n_fail++; $display("FAIL write_other_digit_seg_en: got %b expected 0", seg_en); end
        run_to(96);
        n_checks++; if (digit_sel !== 4'b0100) begin n_fail++; $display("FAIL write_digit_sel: got %b expected 0100", digit_sel); end
        n_checks++; if (digit_code !== 4'h5) begin n_fail++; $display("FAIL write_digit_code: got %h expected 5", digit_code); end
        n_checks++; if (seg_en !== 1'b1) begin n_fail++; $display("FAIL write_seg_en: got %b expected 1", seg_en); end
        test_back_to_back();
    endtask

    // A write accepted during a frame_done cycle waits a whole further frame.
    task automatic test_back_to_back();
        run_to(127);
        n_checks++; if (frame_done !== 1'b1) begin n_fail++; $display("FAIL b2b_frame_done: got %b expected 1", frame_done); end
        n_checks++; if (wr_ready !== 1'b1) begin n_fail++; $display("FAIL b2b_ready: got %b expected 1", wr_ready); end
        wr_valid = 1'b1; wr_digit = 2'd0; wr_data = 4'h9; wr_blank = 1'b0;
        $display("write digit=0 data=9 blank=0 offered at k=%0d", k);
        tick();
        wr_valid = 1'b0;
        n_checks++; if (wr_ready !== 1'b0) begin n_fail++; $display("FAIL b2b_ready_pending: got %b expected 0", wr_ready); end
        n_checks++; if (digit_sel !== 4'b0001) begin n_fail++; $display("FAIL b2b_sel_early: got %b expected 0001", digit_sel); end
        n_checks++; if (digit_code !== 4'h0) begin n_fail++; $display("FAIL b2b_code_early: got %h expected 0", digit_code); end
        n_checks++; if (seg_en !== 1'b0) begin n_fail++; $display("FAIL b2b_seg_en_early: got %b expected 0", seg_en); end
        run_to(191);
        n_checks++; if (wr_ready !== 1'b0) begin n_fail++; $display("FAIL b2b_ready_late: got %b expected 0", wr_ready); end
        n_checks++; if (frame_done !== 1'b1) begin n_fail++; $display("FAIL b2b_frame_done2: got %b expected 1", frame_done); end
        tick();
        n_checks++; if (wr_ready !== 1'b1) begin n_fail++; $display("FAIL b2b_ready_commit: got %b expected 1", wr_ready); end
        n_checks++; if (digit_sel !== 4'b0001) begin n_fail++; $display("FAIL b2b_sel: got %b expected 0001", digit_sel); end
        n_checks++; if (digit_code !== 4'h9) begin n_fail++; $display("FAIL b2b_code: got %h expected 9", digit_code); end
        n_checks++; if (seg_en !== 1'b1) begin n_fail++; $display("FAIL b2b_seg_en: got %b expected 1", seg_en); end
    endtask

    task automatic test_brightness();
        logic       on;
        logic [3:0] exp_sel;
        logic [3:0] exp_code;
        apply_reset();
        // Disabled: commit at the next edge, wr_ready low for exactly one cycle.
        n_checks++; if (wr_ready !== 1'b1) begin n_fail++; $display("FAIL idle_write_ready0: got %b expected 1", wr_ready); end
        wr_valid = 1'b1; wr_digit = 2'd0; wr_data = 4'h3; wr_blank = 1'b0;
        $display("write digit=0 data=3 blank=0 offered while disabled");
        tick();
        wr_valid = 1'b0;
        n_checks++; if (wr_ready !== 1'b0) begin n_fail++; $display("FAIL idle_write_ready1: got %b expected 0", wr_ready); end
        tick();
        n_checks++; if (wr_ready !== 1'b1) begin n_fail++; $display("FAIL idle_write_ready2: got %b expected 1", wr_ready); end
        wr_valid = 1'b1; wr_digit = 2'd1; wr_data = 4'h6; wr_blank = 1'b0;
        $display("write digit=1 data=6 blank=0 offered while disabled");
        tick();
        wr_valid = 1'b0;
        tick();
        brightness = 3'd3;
        start_scan();
        for (int i = 0; i < 32; i++) begin
            on       = (i < 16) ? (i < 8) : ((i - 16) < 2);
            exp_sel  = on ? ((i < 16) ? 4'b0001 : 4'b0010) : 4'b0000;
            exp_code = (i < 16) ? 4'h3 : 4'h6;
            n_checks++; if (digit_sel !== exp_sel) begin n_fail++; $display("FAIL pwm_digit_sel k=%0d: got %b expected %b", k, digit_sel, exp_sel); end
            n_checks++; if (seg_en !== on) begin n_fail++; $display("FAIL pwm_seg_en k=%0d: got %b expected %b", k, seg_en, on); end
            n_checks++; if (digit_code !== exp_code) begin n_fail++; $display("FAIL pwm_digit_code k=%0d: got %h expected %h", k, digit_code, exp_code); end
            if (i == 4) brightness = 3'd0;
            tick();
        end
    endtask

    task automatic test_enable_drop();
        apply_reset();
        brightness = 3'd7;
        start_scan();
        run_to(18);
        wr_valid = 1'b1; wr_digit = 2'd3; wr_data = 4'hA; wr_blank = 1'b0;
        $display("write digit=3 data=a blank=0 offered at k=%0d", k);
        tick();
        wr_valid = 1'b0;
        run_to(21);
        n_checks++; if (digit_sel !== 4'b0010) begin n_fail++; $display("FAIL drop_pre_sel: got %b expected 0010", digit_sel); end
        n_checks++; if (wr_ready !== 1'b0) begin n_fail++; $display("FAIL drop_pre_ready: got %b expected 0", wr_ready); end
        enable = 1'b0;
        tick();
        n_checks++; if (digit_sel !== 4'b0000) begin n_fail++; $display("FAIL drop_digit_sel: got %b expected 0000", digit_sel); end
        n_checks++; if (seg_en !== 1'b0) begin n_fail++; $display("FAIL drop_seg_en: got %b expected 0", seg_en); end
        n_checks++; if (digit_code !== 4'h0) begin n_fail++; $display("FAIL drop_digit_code: got %h expected 0", digit_code); end
        n_checks++; if (frame_done !== 1'b0) begin n_fail++; $display("FAIL drop_frame_done: got %b expected 0", frame_done); end
        n_checks++; if (wr_ready !== 1'b1) begin n_fail++; $display("FAIL drop_wr_ready: got %b expected 1", wr_ready); end
        tick();
        n_checks++; if (digit_sel !== 4'b0000) begin n_fail++; $display("FAIL drop_hold_sel: got %b expected 0000", digit_sel); end
        start_scan();
        n_checks++; if (digit_sel !== 4'b0001) begin n_fail++; $display("FAIL restart_sel: got %b expected 0001", digit_sel); end
        run_to(15);
        n_checks++; if (digit_sel !== 4'b0001) begin n_fail++; $display("FAIL restart_cnt_sel: got %b expected 0001", digit_sel); end
        tick();
        n_checks++; if (digit_sel !== 4'b0010) begin n_fail++; $display("FAIL restart_next_sel: got %b expected 0010", digit_sel); end
        run_to(48);
        n_checks++; if (digit_sel !== 4'b1000) begin n_fail++; $display("FAIL restart_d3_sel: got %b expected 1000", digit_sel); end
        n_checks++; if (digit_code !== 4'hA) begin n_fail++; $display("FAIL restart_d3_code: got %h expected a", digit_code); end
        n_checks++; if (seg_en !== 1'b1) begin n_fail++; $display("FAIL restart_d3_seg_en: got %b expected 1", seg_en); end
    endtask

    task automatic test_out_of_range();
        apply_reset();
        wr_valid3 = 1'b1; wr_digit3 = 2'd1; wr_data3 = 4'h4; wr_blank3 = 1'b0;
        $display("dut3 write digit=1 data=4 blank=0 offered while disabled");
        tick();
        wr_valid3 = 1'b0;
        tick();
        brightness3 = 3'd7;
        enable3 = 1'b1;
        k = -1;
        tick();
        run_to(16);
        n_checks++; if (digit_sel3 !== 3'b010) begin n_fail++; $display("FAIL oor_pre_sel: got %b expected 010", digit_sel3); end
        n_checks++; if (digit_code3 !== 4'h4) begin n_fail++; $display("FAIL oor_pre_code: got %h expected 4", digit_code3); end
        n_checks++; if (seg_en3 !== 1'b1) begin n_fail++; $display("FAIL oor_pre_seg_en: got %b expected 1", seg_en3); end
        run_to(20);
        n_checks++; if (wr_ready3 !== 1'b1) begin n_fail++; $display("FAIL oor_ready: got %b expected 1", wr_ready3); end
        wr_valid3 = 1'b1; wr_digit3 = 2'd3; wr_data3 = 4'h7; wr_blank3 = 1'b0;
        $display("dut3 write digit=3 data=7 blank=0 offered at k=%0d", k);
        tick();
        wr_valid3 = 1'b0;
        n_checks++; if (wr_ready3 !== 1'b0) begin n_fail++; $display("FAIL oor_accepted: got %b expected 0", wr_ready3); end
        run_to(47);
        n_checks++; if (frame_done3 !== 1'b1) begin n_fail++; $display("FAIL oor_frame_done: got %b expected 1", frame_done3); end
        n_checks++; if (wr_ready3 !== 1'b0) begin n_fail++; $display("FAIL oor_ready_pending: got %b expected 0", wr_ready3); end
        tick();
        n_checks++; if (wr_ready3 !== 1'b1) begin n_fail++; $display("FAIL oor_ready_commit: got %b expected 1", wr_ready3); end
        n_checks++; if (digit_sel3 !== 3'b001) begin n_fail++; $display("FAIL oor_d0_sel: got %b expected 001", digit_sel3); end
        n_checks++; if (digit_code3 !== 4'h0) begin n_fail++; $display("FAIL oor_d0_code: got %h expected 0", digit_code3); end
        n_checks++; if (seg_en3 !== 1'b0) begin n_fail++; $display("FAIL oor_d0_seg_en: got %b expected 0", seg_en3); end
        run_to(64);
        n_checks++; if (digit_sel3 !== 3'b010) begin n_fail++; $display("FAIL oor_d1_sel: got %b expected 010", digit_sel3); end
        n_checks++; if (digit_code3 !== 4'h4) begin n_fail++; $display("FAIL oor_d1_code: got %h expected 4", digit_code3); end
        n_checks++; if (seg_en3 !== 1'b1) begin n_fail++; $display("FAIL oor_d1_seg_en: got %b expected 1", seg_en3); end
        run_to(80);
        n_checks++; if (digit_sel3 !== 3'b100) begin n_fail++; $display("FAIL oor_d2_sel: got %b expected 100", digit_sel3); end
        n_checks++; if (digit_code3 !== 4'h0) begin n_fail++; $display("FAIL oor_d2_code: got %h expected 0", digit_code3); end
        n_checks++; if (seg_en3 !== 1'b0) begin n_fail++; $display("FAIL oor_d2_seg_en: got %b expected 0", seg_en3); end
        run_to(95);
        n_checks++; if (frame_done3 !== 1'b1) begin n_fail++; $display("FAIL oor_frame_done2: got %b expected 1", frame_done3); end
    endtask

    initial begin
        #200000;
        $display("FAIL watchdog: simulation time limit reached, k=%0d", k);
        $fatal(1, "watchdog expired");
    end

    initial begin
        test_reset();
        test_scan();
        test_write();
        test_brightness();
        test_enable_drop();
        test_out_of_range();
        $display("End of test - %0d assertions evaluated, %0d failures", n_checks, n_fail);
        $finish;
    end

endmodule
